// File: rtl/spi_resp_encoder.sv
// Builds the 16-bit response word for the SPI TX shifter from decoded commands:
// register read data, write acknowledges, read-timeout errors, or a status filler.
package spi_resp_pkg;
  typedef struct packed {
    logic       valid;
    logic       write;
    logic       to_register;
    logic [7:0] payload;
  } decoded_cmd_t;
endpackage

module spi_resp_encoder
  import spi_resp_pkg::*;
#(
  parameter int unsigned P_TIMEOUT  = 16,
  parameter logic [7:0]  P_IDLE_HDR = 8'hA5,
  parameter logic [7:0]  P_ACK_HDR  = 8'h5A,
  parameter logic [7:0]  P_ERR_HDR  = 8'hEE
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_spi_csn,
  input  decoded_cmd_t i_command,
  output logic         o_reg_rd,
  output logic [7:0]   o_reg_addr,
  input  logic [15:0]  i_reg_data,
  input  logic         i_reg_ack,
  output logic [15:0]  o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready
);
  localparam int unsigned CW = $clog2(P_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, LOAD} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [15:0]   resp;
  logic          timeout_err;
  logic          overrun;
  logic          last_write;
  logic [7:0]    status;
  logic          accepted;

  assign status   = {5'b0, timeout_err, overrun, last_write};
  assign accepted = i_command.valid & i_command.to_register & ~i_spi_csn;

  // Whenever no response is pending the shifter sees the live status filler.
  assign o_tx_data = o_tx_valid ? resp : {P_IDLE_HDR, status};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      count       <= '0;
      resp        <= '0;
      o_reg_rd    <= 1'b0;
      o_reg_addr  <= 8'h00;
      o_tx_valid  <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      last_write  <= 1'b0;
    end else if (i_spi_csn) begin
      state       <= IDLE;
      o_reg_rd    <= 1'b0;
      o_tx_valid  <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      last_write  <= 1'b0;
    end else begin
      o_reg_rd <= 1'b0;
      if (accepted && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accepted) begin
            if (i_command.write) begin
              resp       <= {P_ACK_HDR, i_command.payload};
              o_tx_valid <= 1'b1;
              last_write <= 1'b1;
              state      <= LOAD;
            end else begin
              o_reg_addr <= i_command.payload;
              o_reg_rd   <= 1'b1;
              count      <= '0;
              last_write <= 1'b0;
              state      <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // count is 0 on the strobe cycle; an ack on the final cycle still wins.
          if (i_reg_ack) begin
            resp       <= i_reg_data;
            o_tx_valid <= 1'b1;
            state      <= LOAD;
          end else if (count == CW'(P_TIMEOUT - 1)) begin
            resp        <= {P_ERR_HDR, o_reg_addr};
            o_tx_valid  <= 1'b1;
            timeout_err <= 1'b1;
            state       <= LOAD;
          end else begin
            count <= count + 1'b1;
          end
        end
        LOAD: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_resp_encoder.sv
// Directed bench for spi_resp_encoder: a transaction-level model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_spi_resp_encoder;
  import spi_resp_pkg::*;

  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         csn = 1'b1;
  decoded_cmd_t cmd = '0;
  logic         reg_rd;
  logic [7:0]   reg_addr;
  logic [15:0]  reg_data = 16'h0000;
  logic         reg_ack = 1'b0;
  logic [15:0]  tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int rd_pulses = 0;

  spi_resp_encoder #(.P_TIMEOUT(TMO)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_spi_csn  (csn),
    .i_command  (cmd),
    .o_reg_rd   (reg_rd),
    .o_reg_addr (reg_addr),
    .i_reg_data (reg_data),
    .i_reg_ack  (reg_ack),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  // Transaction-level model: a pending read with its strobe cycle, or a held response.
  int          m_cyc = 0;
  int          m_strobe = -1;
  bit          m_pending = 0;
  bit          m_valid = 0;
  logic [15:0] m_resp = '0;
  logic [7:0]  m_addr = '0;
  bit          m_terr = 0, m_ovr = 0, m_lw = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pending = 0; m_valid = 0; m_addr = 8'h00;
        m_terr = 0; m_ovr = 0; m_lw = 0;
      end else if (csn) begin
        m_pending = 0; m_valid = 0;
        m_terr = 0; m_ovr = 0; m_lw = 0;
        m_cyc++;
      end else begin
        bit busy;
        busy = m_pending || m_valid;
        if (m_pending) begin
          if (reg_ack) begin
            m_valid = 1; m_resp = reg_data; m_pending = 0;
          end else if (m_cyc - m_strobe + 1 == int'(TMO)) begin
            m_valid = 1; m_resp = {8'hEE, m_addr}; m_terr = 1; m_pending = 0;
          end
        end else if (m_valid && tx_ready) begin
          m_valid = 0;
        end
        if (cmd.valid && cmd.to_register) begin
          if (busy) m_ovr = 1;
          else if (cmd.write) begin
            m_valid = 1; m_resp = {8'h5A, cmd.payload}; m_lw = 1;
          end else begin
            m_pending = 1; m_addr = cmd.payload; m_strobe = m_cyc + 1; m_lw = 0;
          end
        end
        m_cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reg_rd === 1'b1) rd_pulses++;
      check("reg_rd", {15'b0, reg_rd}, {15'b0, m_pending && (m_cyc == m_strobe)});
      check("reg_addr", {8'h00, reg_addr}, {8'h00, m_addr});
      check("tx_valid", {15'b0, tx_valid}, {15'b0, m_valid});
      check("tx_data", tx_data, m_valid ? m_resp : {8'hA5, 5'b0, m_terr, m_ovr, m_lw});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [7:0] pl);
    cmd = '{valid: 1'b1, write: wr, to_register: 1'b1, payload: pl};
    step();
    cmd = '0;
  endtask

  task automatic consume();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
  endtask

  initial begin
    int n;
    step();
    step();
    check("reset_tx_data", tx_data, 16'hA500);
    check("reset_tx_valid", {15'b0, tx_valid}, 16'h0000);
    rst_n = 1'b1;
    csn = 1'b0;
    step();

    // Read 0x12, ack with BEEF three cycles after the strobe.
    rd_pulses = 0;
    send(1'b0, 8'h12);
    check("rd1_strobe", {15'b0, reg_rd}, 16'h0001);
    check("rd1_addr", {8'h00, reg_addr}, 16'h0012);
    repeat (3) step();
    reg_ack = 1'b1; reg_data = 16'hBEEF;
    step();
    reg_ack = 1'b0; reg_data = 16'h0000;
    repeat (2) step();
    check("rd1_data", tx_data, 16'hBEEF);
    check("rd1_valid", {15'b0, tx_valid}, 16'h0001);
    consume();
    check("rd1_filler", tx_data, 16'hA500);
    check("rd1_pulses", 16'(rd_pulses), 16'd1);

    // Write 0x34: response one cycle after the command.
    send(1'b1, 8'h34);
    check("wr_valid", {15'b0, tx_valid}, 16'h0001);
    check("wr_data", tx_data, 16'h5A34);
    step();
    consume();
    check("wr_filler", tx_data, 16'hA501);

    // Read 0x07 with no ack: error word 16 cycles after the strobe.
    send(1'b0, 8'h07);
    n = 0;
    while (tx_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("tmo_cycles", 16'(n), 16'(TMO));
    check("tmo_data", tx_data, 16'hEE07);
    consume();
    check("tmo_filler", tx_data, 16'hA504);

    // New frame: second read while the first is in flight is an overrun.
    csn = 1'b1; step(); csn = 1'b0; step();
    check("frame_clear", tx_data, 16'hA500);
    rd_pulses = 0;
    send(1'b0, 8'h20);
    step();
    send(1'b0, 8'h21);
    check("ovr_addr_held", {8'h00, reg_addr}, 16'h0020);
    reg_ack = 1'b1; reg_data = 16'h1234;
    step();
    reg_ack = 1'b0;
    check("ovr_data", tx_data, 16'h1234);
    consume();
    check("ovr_filler", tx_data, 16'hA502);
    check("ovr_pulses", 16'(rd_pulses), 16'd1);

    // Abort a read with CSn high; the late ack must be ignored.
    csn = 1'b1; step(); csn = 1'b0; step();
    send(1'b0, 8'h30);
    step();
    csn = 1'b1;
    step();
    csn = 1'b0;
    reg_ack = 1'b1; reg_data = 16'hDEAD;
    step();
    reg_ack = 1'b0;
    repeat (2) step();
    check("abort_valid", {15'b0, tx_valid}, 16'h0000);
    check("abort_data", tx_data, 16'hA500);
    send(1'b1, 8'h66);
    check("abort_idle_wr", tx_data, 16'h5A66);

    // Asynchronous reset while holding a response.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {15'b0, tx_valid}, 16'h0000);
    check("arst_data", tx_data, 16'hA500);
    check("arst_addr", {8'h00, reg_addr}, 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    send(1'b0, 8'h44);
    reg_ack = 1'b1; reg_data = 16'hCAFE;
    step();
    reg_ack = 1'b0;
    check("post_rst_valid", {15'b0, tx_valid}, 16'h0001);
    check("post_rst_data", tx_data, 16'hCAFE);
    consume();
    check("post_rst_filler", tx_data, 16'hA500);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/spi_resp_encoder.md
Name: spi_resp_encoder

Overview:
- Transmit-side counterpart of the SPI command decoder: consumes decoded commands and builds the 16-bit word the SPI slave shifts out on the next frame.
- READ: fetches register data over a request/ack bus and queues it; WRITE: queues an acknowledge word.
- Otherwise presents a status filler word.
- Sits between the command decoder and the SPI slave TX shift register, alongside the register bank.

Parameters:
- P_TIMEOUT, 16, cycles waited for i_reg_ack before abort (>=1).
- P_IDLE_HDR, 8'hA5, header byte of the filler/status word.
- P_ACK_HDR, 8'h5A, header byte of the write-acknowledge word.
- P_ERR_HDR, 8'hEE, header byte of the read-timeout error word.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_spi_csn  in  1  SPI chip select, high = no frame.
- i_command  in  decoded_cmd_t  decoded command; fields valid, write, to_register, payload[7:0] used.
- o_reg_rd  out  1  one-cycle register read strobe.
- o_reg_addr  out  8  register address, held from strobe until ack/timeout.
- i_reg_data  in  16  read data, sampled when i_reg_ack=1.
- i_reg_ack  in  1  read complete.
- o_tx_data  out  16  word for the SPI TX shifter; always meaningful.
- o_tx_valid  out  1  o_tx_data holds a fresh response.
- i_tx_ready  in  1  shifter loaded o_tx_data this cycle.

Behaviour:
- Reset: state IDLE, o_reg_rd=0, o_reg_addr=0, o_tx_valid=0, status=0, o_tx_data={P_IDLE_HDR,8'h00}.
- Status byte = {5'b0, timeout_err, overrun, last_write}.
- Accepted command: i_command.valid & to_register & ~i_spi_csn.
- FSM:
  - IDLE. o_tx_data={P_IDLE_HDR,status}.
    - Accepted READ: o_reg_addr<=payload, o_reg_rd<=1 next cycle, go RD_WAIT; last_write<=0.
    - Accepted WRITE: o_tx_data<={P_ACK_HDR,payload}, o_tx_valid<=1, go LOAD; last_write<=1.
  - RD_WAIT. o_reg_rd high only on the first cycle. Counter counts cycles since the strobe.
    - i_reg_ack: o_tx_data<=i_reg_data, o_tx_valid<=1, go LOAD.
    - Counter reaches P_TIMEOUT without ack: o_tx_data<={P_ERR_HDR,o_reg_addr}, o_tx_valid<=1, timeout_err<=1, go LOAD.
    - Ack on the same cycle as the timeout: ack wins.
  - LOAD. Hold o_tx_data/o_tx_valid until i_tx_ready=1. Then o_tx_valid<=0, go IDLE, and o_tx_data shows the filler next cycle.
- Latency:
  - READ with a combinational ack on the strobe cycle: o_tx_valid 2 cycles after the command.
  - WRITE: o_tx_valid 1 cycle after the command.
- Overrun: an accepted command while not IDLE is ignored and sets overrun<=1.
- i_tx_ready while o_tx_valid=0: no effect.
- CSn high (any state, any cycle): go IDLE, o_reg_rd<=0, o_tx_valid<=0, status<=0, o_tx_data<={P_IDLE_HDR,8'h00}.
  - A late i_reg_ack after abort is ignored.
  - CSn high takes priority over every other event that cycle.
- Status flags are sticky within a frame and cleared only by CSn high or reset.
- Reset mid-operation: immediate return to reset values; no pending read is reissued.
- o_reg_addr is never changed while in RD_WAIT.

Test Plan:
- CSn low, READ addr 8'h12; i_reg_ack with 16'hBEEF 3 cycles after the strobe -> one o_reg_rd pulse, o_reg_addr=8'h12, o_tx_data=16'hBEEF with o_tx_valid until i_tx_ready. Then filler 16'hA500.
- WRITE payload 8'h34 -> o_tx_data=16'h5A34, o_tx_valid 1 cycle later. After consumption, filler=16'hA501 (last_write).
- READ addr 8'h07, no ack -> after exactly 16 cycles o_tx_data=16'hEE07, valid. After consumption, filler=16'hA504.
- READ in flight plus second READ before the ack -> second ignored, single o_reg_rd. After the response, filler=16'hA502.
- READ, CSn raised in RD_WAIT, ack arrives the next cycle -> o_tx_valid stays 0, o_tx_data=16'hA500, FSM IDLE, ack ignored.
- Assert i_rst_n=0 while in LOAD -> outputs immediately return to reset values asynchronously; after release, a READ works normally.
